// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver. It synchronises RXD, samples each bit at its centre and strobes DATA_READY or FRAME_ERROR.
// Optional build macro UART_RECV_MAJORITY_EN: 2-of-3 majority vote around each sample point, decided one clock later.
module uart_recv #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       DATA_READY,
  output logic       FRAME_ERROR,
  output logic       IDLE
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RECV_MAJORITY_EN
  // Voting needs centre+1, so the start decision and everything after it shifts one clock.
  localparam int START_CHK = HALF;
`else
  localparam int START_CHK = HALF - 1;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(START_CHK);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state;
  logic          rxd_m, rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_val;

`ifdef UART_RECV_MAJORITY_EN
  logic rxd_p1, rxd_p2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p1 <= rxd_s;
      rxd_p2 <= rxd_p1;
    end
  end

  assign bit_val = (rxd_s & rxd_p1) | (rxd_s & rxd_p2) | (rxd_p1 & rxd_p2);
`else
  assign bit_val = rxd_s;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      DATA        <= '0;
      DATA_READY  <= 1'b0;
      FRAME_ERROR <= 1'b0;
      IDLE        <= 1'b1;
    end else begin
      rxd_m       <= RXD;
      rxd_s       <= rxd_m;
      DATA_READY  <= 1'b0;
      FRAME_ERROR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
            IDLE  <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == START_LAST) begin
            cnt <= '0;
            idx <= '0;
            if (!bit_val) begin
              state <= S_DATA;
            end else begin
              // A start bit that is gone by its centre is a glitch.
              state <= S_IDLE;
              IDLE  <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {bit_val, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_val) begin
              DATA       <= shreg;
              DATA_READY <= 1'b1;
              state      <= S_IDLE;
              IDLE       <= 1'b1;
            end else begin
              FRAME_ERROR <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_BREAK: begin
          // Hold off until the line returns high so a held-low break cannot retrigger.
          if (rxd_s) begin
            state <= S_IDLE;
            IDLE  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          IDLE  <= 1'b1;
        end
      endcase
    end
  end
endmodule
